// File: rtl/hz_pkg.sv
// Shared types for the pipeline hazard controller: shadow slot layout,
// forwarding select encodings, FSM state enum and the slot/source match rule.
package hz_pkg;

   localparam int unsigned HZ_REG_W = 5;

   // Destination metadata carried alongside one pipeline stage.
   typedef struct packed {
      logic                valid;
      logic [HZ_REG_W-1:0] rd;
      logic                writes;
      logic                is_load;
      logic                is_mem;
   } slot_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StStall   = 2'd1,
      StMemWait = 2'd2,
      StFlush   = 2'd3
   } hz_state_e;

   // A slot produces a value the source needs; x0 is never a producer.
   function automatic logic slot_match(input slot_t s, input logic [HZ_REG_W-1:0] src,
                                       input logic uses);
      return s.valid && s.writes && (s.rd != '0) && (s.rd == src) && uses;
   endfunction

endpackage

// File: rtl/hz_slot_reg.sv
// One shadow slot: loads i_d (or an empty slot when i_clear) on i_load, else holds.
module hz_slot_reg
   import hz_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_reset,
   input  logic  i_load,
   input  logic  i_clear,
   input  slot_t i_d,
   output slot_t o_q
);

   slot_t r_q;

   // Slot register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_clear ? '0 : i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush control and EX forwarding selects for the 5-stage pipeline.
// Optional feature macro: PIPE_FORWARD_EN (forwarding paths present, stall only on load-use).
module pipeline_hazard_ctrl
   import hz_pkg::*;
#(
   parameter int unsigned REG_W = HZ_REG_W,
   parameter int unsigned CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   input  logic [REG_W-1:0] i_id_rd,
   input  logic             i_id_writes_rd,
   input  logic             i_id_is_load,
   input  logic             i_id_is_mem,
   input  logic             i_ex_branch_taken,
   input  logic             i_mem_ready,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_id_ex_en,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_bubble,
   output logic [1:0]       o_fwd_a_sel,
   output logic [1:0]       o_fwd_b_sel,
   output logic [1:0]       o_hz_state,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count
);

   slot_t      w_id_slot, w_ex, w_mem, w_wb;
   logic       w_adv, w_bubble, w_mem_wait, w_hazard;
   logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b;
   hz_state_e  w_state_d, r_state;
   logic [CNT_W-1:0] r_stall_cycles, r_flush_count;

   assign w_id_slot = '{valid:   i_id_valid,
                        rd:      i_id_rd,
                        writes:  i_id_writes_rd,
                        is_load: i_id_is_load,
                        is_mem:  i_id_is_mem};

   hz_slot_reg u_slot_ex (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_adv),
      .i_clear (w_bubble),
      .i_d     (w_id_slot),
      .o_q     (w_ex)
   );

   hz_slot_reg u_slot_mem (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_adv),
      .i_clear (1'b0),
      .i_d     (w_ex),
      .o_q     (w_mem)
   );

   hz_slot_reg u_slot_wb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_adv),
      .i_clear (1'b0),
      .i_d     (w_mem),
      .o_q     (w_wb)
   );

   assign w_ex_a  = slot_match(w_ex, i_id_rs1, i_id_uses_rs1);
   assign w_ex_b  = slot_match(w_ex, i_id_rs2, i_id_uses_rs2);
   assign w_mem_a = slot_match(w_mem, i_id_rs1, i_id_uses_rs1);
   assign w_mem_b = slot_match(w_mem, i_id_rs2, i_id_uses_rs2);

   assign w_mem_wait = w_mem.valid & w_mem.is_mem & ~i_mem_ready;

`ifdef PIPE_FORWARD_EN
   assign w_hazard = i_id_valid & w_ex.is_load & (w_ex_a | w_ex_b);
`else
   // WB never hazards: the register file writes before it is read.
   assign w_hazard = i_id_valid & (w_ex_a | w_ex_b | w_mem_a | w_mem_b);
`endif

   // WB slot and a few fields are kept for completeness but not decoded.
   logic w_unused_slot;
   assign w_unused_slot = ^{w_wb, w_ex.is_mem, w_ex.is_load, w_mem.is_load};

   // Priority decode: freeze > branch flush > hazard stall > run.
   always_comb begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
      o_mem_wb_en    = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      w_adv          = 1'b0;
      w_bubble       = 1'b0;
      w_state_d      = StRun;
      if (i_reset) begin
         w_state_d = StRun;
      end else if (w_mem_wait) begin
         w_state_d = StMemWait;
      end else if (i_ex_branch_taken) begin
         o_pc_en        = 1'b1;
         o_if_id_en     = 1'b1;
         o_id_ex_en     = 1'b1;
         o_ex_mem_en    = 1'b1;
         o_mem_wb_en    = 1'b1;
         o_if_id_flush  = 1'b1;
         o_id_ex_bubble = 1'b1;
         w_adv          = 1'b1;
         w_bubble       = 1'b1;
         w_state_d      = StFlush;
      end else if (w_hazard) begin
         o_id_ex_en     = 1'b1;
         o_ex_mem_en    = 1'b1;
         o_mem_wb_en    = 1'b1;
         o_id_ex_bubble = 1'b1;
         w_adv          = 1'b1;
         w_bubble       = 1'b1;
         w_state_d      = StStall;
      end else begin
         o_pc_en     = 1'b1;
         o_if_id_en  = 1'b1;
         o_id_ex_en  = 1'b1;
         o_ex_mem_en = 1'b1;
         o_mem_wb_en = 1'b1;
         w_adv       = 1'b1;
      end
   end

   // FSM state register: records the winning case of each cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Wrapping stall and flush event counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_state_d == StMemWait || w_state_d == StStall) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (w_state_d == StFlush) begin
            r_flush_count <= r_flush_count + CNT_W'(1);
         end
      end
   end

`ifdef PIPE_FORWARD_EN
   logic [1:0] r_fwd_a, r_fwd_b;
   logic [1:0] w_fwd_a_d, w_fwd_b_d;

   // Youngest producer (EX) wins over MEM.
   assign w_fwd_a_d = w_ex_a ? FWD_EXMEM : (w_mem_a ? FWD_MEMWB : FWD_RF);
   assign w_fwd_b_d = w_ex_b ? FWD_EXMEM : (w_mem_b ? FWD_MEMWB : FWD_RF);

   // Selects move with the instruction entering EX; hold while frozen.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else if (w_adv) begin
         r_fwd_a <= w_bubble ? FWD_RF : w_fwd_a_d;
         r_fwd_b <= w_bubble ? FWD_RF : w_fwd_b_d;
      end
   end

   assign o_fwd_a_sel = r_fwd_a;
   assign o_fwd_b_sel = r_fwd_b;
`else
   assign o_fwd_a_sel = FWD_RF;
   assign o_fwd_b_sel = FWD_RF;
`endif

   assign o_hz_state     = r_state;
   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_count  = r_flush_count;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Backward-flowing control for the 5-stage pipeline: decides every cycle whether each pipeline register loads, holds, or takes a bubble, and produces the EX-stage forwarding selects. It keeps a shadow copy of destination-register metadata for the EX, MEM and WB stages. From that copy it detects load-use and RAW hazards, handles taken-branch flushes and data-memory wait states, and drives the enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.

## Interface
- REG_W, 5, register-index width
- CNT_W, 32, stall/flush counter width
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  ID source indices
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  REG_W  ID destination index
- id_writes_rd  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_mem  in  1  ID instruction is load or store
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_ready  in  1  data memory completes the access in MEM this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile/ID/EX, 01 EX/MEM result, 10 MEM/WB result
- hz_state  out  2  current FSM state
- stall_cycles, flush_count  out  CNT_W  wrapping event counters

## Operation
- Shadow slots EX, MEM, WB hold {valid, rd, writes, is_load, is_mem}. A slot matches a source when: valid, writes, rd≠0, rd equals the source index, and the corresponding id_uses_rsN is 1.
- Slot advance when the pipeline is not frozen: WB←MEM, MEM←EX, EX←ID fields (valid=id_valid). On a bubble, EX slot valid=0.
- Priority, highest first:
  1. MEM_WAIT: MEM slot valid & is_mem & !mem_ready. All enables 0, no flush, no bubble, slots hold.
  2. Branch: ex_branch_taken. pc_en=1 (PC loads target), if_id_flush=1, id_ex_bubble=1, downstream enables 1. Any concurrent load-use stall is discarded.
  3. Hazard stall. pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en and mem_wb_en stay 1.
  4. RUN: all enables 1.
- FSM states RUN=0, STALL=1, MEM_WAIT=2, FLUSH=3. hz_state registers the winning case of each cycle and is visible the next cycle.
- stall_cycles increments on every cycle of case 1 or case 3. flush_count increments on every case-2 cycle.
- Forwarding selects are registered when ID advances into EX:
  - 01 if the source matches the EX slot (the youngest producer wins).
  - else 10 if the source matches the MEM slot.
  - else 00.
- On a bubble the selects load 00. Under MEM_WAIT they hold.

## Timing
- Reset values: slots invalid, fwd_a_sel/fwd_b_sel=00, counters 0, hz_state=RUN. While reset=1 all enables, if_id_flush and id_ex_bubble are 0.
- Reset asserted mid-stall or mid-wait aborts the stall or wait at the next edge. No residual bubble is issued.
- Enables, flush and bubble are combinational from slots and inputs, valid in the same cycle. The forwarding selects have 1-cycle latency and line up with the instruction in EX.
- A load-use hazard costs exactly 1 stall cycle with forwarding enabled. A taken branch costs 2 flushed slots.
- mem_ready low for N cycles gives exactly N frozen cycles. When a branch is pending under a freeze, it is acted on in the first unfrozen cycle.
- Register x0 never produces a hazard or a forward.

## Configuration
- PIPE_FORWARD_EN defined: hazard stall only on load-use, i.e. the EX slot is_load and matches. Forwarding selects are active.
- PIPE_FORWARD_EN undefined:
  - Hazard stall whenever a source matches the EX or MEM slot.
  - The WB slot is never a hazard, because the register file is write-before-read.
  - fwd_a_sel/fwd_b_sel are tied to 00.

## Structure
- A shared package hz_pkg holds the slot struct typedef, the fwd select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the FSM state enum.
- One natural sub-module, hz_slot_reg: a single shadow slot with load/clear/hold controls, instantiated three times.

## Test plan
- Load x5 in EX, ID reads x5 (FORWARD_EN): 1 cycle with pc_en=0, id_ex_bubble=1, stall_cycles=1. The next EX cycle has fwd_a_sel=10.
- ADD x3 in EX, ID uses rs2=x3: no stall, fwd_b_sel=01 one cycle later. With the macro undefined, 2 stall cycles and fwd_b_sel=00.
- ex_branch_taken=1 coincident with a load-use hazard: if_id_flush=1, id_ex_bubble=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- Store in MEM, mem_ready low for 3 cycles: all enables 0 for 3 cycles, hz_state=MEM_WAIT, stall_cycles=3, slots unchanged.
- ID writes/reads x0 with producer x0 in EX: no stall, selects 00.
- reset asserted during MEM_WAIT: the next cycle has slots invalid, hz_state=RUN, counters 0, and all enables 1 once reset drops.
